mem_port: RTL and testbench
===========================

Name: mem_port

Overview:
- Memory-access initiator that drives the single-port byte-addressed RAM on behalf of the CPU load/store stage.
- Converts CPU byte, halfword and word loads and stores into `RAM_READ / `RAM_WRITE cycles at word-aligned addresses, with big-endian lanes.
- Performs read-modify-write for sub-word stores.
- Checks alignment and range, and reports completion with a one-cycle done pulse.

Parameters:
- MEM_SIZE, 1024, RAM size in bytes; must match the RAM's `MEM_SIZE and be a multiple of 4.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_req  input  1  CPU request strobe; sampled only in IDLE.
- i_we  input  1  1 = store, 0 = load.
- i_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 = illegal.
- i_signed  input  1  load sign-extends when 1, zero-extends when 0.
- i_addr  input  32  byte address.
- i_wdata  input  32  store data; byte uses [7:0], halfword uses [15:0].
- o_ready  output  1  high in IDLE only.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  valid with o_done; misaligned, out-of-range or illegal-size request.
- o_rdata  output  32  load result; held until the next completing load.
- o_ram_action  output  2  `RAM_NONE, `RAM_READ or `RAM_WRITE.
- o_ram_addr  output  32  always word-aligned ({addr[31:2], 2'b00}).
- o_ram_val  output  32  write word.
- i_ram_val  input  32  RAM read word; combinational from o_ram_addr.

Behaviour:
- Reset (async, takes effect immediately, also mid-operation):
  - state = IDLE; o_ram_action = `RAM_NONE; o_done = 0; o_err = 0; o_rdata = 0; internal latches cleared.
  - A transaction interrupted by reset issues no further RAM write.
- States: IDLE, RD, RMW, WR, DONE, ERR. All outputs are decoded from registered state and latches only; no input-to-output combinational path except RAM data capture.
- IDLE:
  - o_ready = 1; o_ram_action = `RAM_NONE.
  - On i_req = 1, latch i_we, i_size, i_signed, i_addr and i_wdata. Later input changes are ignored until the next IDLE.
  - Error condition: i_size = 3; or halfword with addr[0] = 1; or word with addr[1:0] != 0; or aligned address > MEM_SIZE-4. Error goes to ERR.
  - Otherwise: load goes to RD; word store goes to WR; byte or halfword store goes to RMW.
- RD:
  - Drive `RAM_READ at the aligned address.
  - At the clock edge, extract the lane from i_ram_val, extend it per the latched i_signed, and register into o_rdata. Then go to DONE.
- RMW:
  - Drive `RAM_READ at the aligned address.
  - At the clock edge, capture i_ram_val, replace the target lane with the latched wdata, and store the merged word. Then go to WR.
- WR:
  - Drive `RAM_WRITE, o_ram_addr = aligned address, o_ram_val = merged word (word store: latched wdata). The RAM commits at this edge.
  - Then go to DONE.
- DONE: o_done = 1, o_err = 0 for one cycle; then go to IDLE.
- ERR:
  - o_done = 1, o_err = 1 for one cycle, with no RAM access; then go to IDLE.
  - o_rdata is unchanged.
- Lanes (big-endian):
  - Byte offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - Halfword offset 0 = [31:16], 2 = [15:0].
- Latency, counted from the edge that accepts i_req to the cycle o_done is high:
  - load 2;
  - word store 2;
  - sub-word store 3;
  - error 1.
- Back-to-back: the earliest next acceptance is the edge after DONE/ERR, i.e. in IDLE. i_req asserted while not IDLE is dropped, not queued.
- o_ram_val is 0 whenever o_ram_action != `RAM_WRITE.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> exactly one `RAM_WRITE cycle, o_done 2 cycles after accept; load o_rdata = 0xDEADBEEF, o_err = 0.
- Byte store 0xA5 @0x11 -> RMW then WR, done on 3rd cycle; word load @0x10 = 0xDEA5BEEF. Signed byte load @0x11 = 0xFFFFFFA5; unsigned = 0x000000A5.
- Halfword store 0x1234 @0x12 -> word = 0xDEA51234. Signed half load @0x10 = 0xFFFFDEA5.
- Misaligned cases:
  - word load @0x13 -> o_done = o_err = 1 one cycle after accept, no RAM action, o_rdata unchanged;
  - half store @0x11 -> error, and memory @0x10 still 0xDEA51234.
- Range check: word store @MEM_SIZE-4 succeeds; @MEM_SIZE -> o_err = 1; illegal i_size = 3 -> o_err = 1.
- Assert i_rst during RMW of a byte store -> o_ram_action = `RAM_NONE immediately, no `RAM_WRITE ever issued, memory unchanged. i_req pulses while busy are ignored; only one o_done per accepted request.

Source files
------------

// File: rtl/mem_port.sv
// rtl/mem_port.sv - CPU load/store to word-aligned big-endian single-port RAM initiator
`ifndef RAM_NONE
`define RAM_NONE  2'd0
`endif
`ifndef RAM_READ
`define RAM_READ  2'd1
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd2
`endif

module mem_port #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_ram_action,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_val,
    input  logic [31:0] i_ram_val
);
    localparam logic [31:0] LAST_WORD = 32'(MEM_SIZE - 4);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RMW, S_WR, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wval_q, wval_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_err;

    // Lane 0 is the most significant byte, so the shift is (3 - offset) lanes.
    function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        res = word;
        if (size == 2'd0) begin
            sh  = word >> {~off, 3'b000};
            res = (sgn && sh[7]) ? {24'hFF_FFFF, sh[7:0]} : {24'h0, sh[7:0]};
        end else if (size == 2'd1) begin
            sh  = word >> {~off[1], 4'b0000};
            res = (sgn && sh[15]) ? {16'hFFFF, sh[15:0]} : {16'h0, sh[15:0]};
        end
        return res;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == 2'd0) begin
            mask = 32'h0000_00FF << {~off, 3'b000};
            data = {24'h0, wdata[7:0]} << {~off, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {~off[1], 4'b0000};
            data = {16'h0, wdata[15:0]} << {~off[1], 4'b0000};
        end
        return (word & ~mask) | data;
    endfunction

    always_comb begin
        req_err = (i_size == 2'd3) ||
                  (i_size == 2'd1 && i_addr[0]) ||
                  (i_size == 2'd2 && i_addr[1:0] != 2'b00) ||
                  ({i_addr[31:2], 2'b00} > LAST_WORD);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wval_d   = wval_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    we_d     = i_we;
                    size_d   = i_size;
                    signed_d = i_signed;
                    addr_d   = i_addr;
                    wval_d   = i_wdata;
                    if (req_err)              state_d = S_ERR;
                    else if (!i_we)           state_d = S_RD;
                    else if (i_size == 2'd2)  state_d = S_WR;
                    else                      state_d = S_RMW;
                end
            end
            S_RD: begin
                rdata_d = load_lane(i_ram_val, size_q, signed_q, addr_q[1:0]);
                state_d = S_DONE;
            end
            S_RMW: begin
                wval_d  = merge_lane(i_ram_val, wval_q, size_q, addr_q[1:0]);
                state_d = S_WR;
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wval_q   <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wval_q   <= wval_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        o_ready      = (state_q == S_IDLE);
        o_done       = (state_q == S_DONE) || (state_q == S_ERR);
        o_err        = (state_q == S_ERR);
        o_rdata      = rdata_q;
        o_ram_addr   = {addr_q[31:2], 2'b00};
        o_ram_action = `RAM_NONE;
        o_ram_val    = 32'h0;
        if (state_q == S_RD || state_q == S_RMW) begin
            o_ram_action = `RAM_READ;
        end else if (state_q == S_WR) begin
            o_ram_action = `RAM_WRITE;
            o_ram_val    = wval_q;
        end
    end

    // we_q is latched for completeness of the request record; routing is decided in IDLE.
    logic unused_we;
    assign unused_we = we_q;
endmodule

// File: tb/tb_mem_port.sv
// tb/tb_mem_port.sv - scoreboard bench for mem_port against a byte-array memory model
`ifndef RAM_NONE
`define RAM_NONE  2'd0
`endif
`ifndef RAM_READ
`define RAM_READ  2'd1
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd2
`endif

module tb_mem_port;
    localparam int unsigned MEM_SIZE = 1024;
    localparam int AW = $clog2(MEM_SIZE);

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'd0;
    logic        i_signed = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        o_ready, o_done, o_err;
    logic [31:0] o_rdata, o_ram_addr, o_ram_val, i_ram_val;
    logic [1:0]  o_ram_action;

    mem_port #(.MEM_SIZE(MEM_SIZE)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_size(i_size),
        .i_signed(i_signed), .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready),
        .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_ram_action(o_ram_action),
        .o_ram_addr(o_ram_addr), .o_ram_val(o_ram_val), .i_ram_val(i_ram_val)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          actions;
        int          writes;
        int          acc;
        logic [31:0] wa;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram_w [MEM_SIZE/4];
    logic [7:0]  mem_b [MEM_SIZE];
    logic [31:0] last_rdata = 32'h0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          act_cnt = 0;
    int          wr_cnt = 0;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Behavioural RAM: combinational read, commit on the write edge.
    assign i_ram_val = (o_ram_addr < MEM_SIZE) ? ram_w[o_ram_addr[AW-1:2]] : 32'h0;
    initial begin
        for (int i = 0; i < MEM_SIZE/4; i++)
            ram_w[i] = {pat(4*i), pat(4*i+1), pat(4*i+2), pat(4*i+3)};
        forever begin
            @(posedge i_clk);
            if (o_ram_action == `RAM_WRITE && o_ram_addr < MEM_SIZE)
                ram_w[o_ram_addr[AW-1:2]] = o_ram_val;
        end
    end

    always @(posedge i_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] wa);
        int b;
        b = int'(wa);
        return {mem_b[b], mem_b[b+1], mem_b[b+2], mem_b[b+3]};
    endfunction

    task automatic model_req(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        logic [31:0] wa;
        logic [15:0] h;
        int b;
        wa = a & 32'hFFFF_FFFC;
        b  = int'(a);
        e.wa = wa;
        e.err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
                || (wa > MEM_SIZE - 4);
        e.writes = 0;
        if (e.err) begin
            e.lat = 1; e.actions = 0;
        end else if (!we) begin
            e.lat = 2; e.actions = 1;
            if (sz == 2'd0)
                last_rdata = (sg && mem_b[b][7]) ? {24'hFF_FFFF, mem_b[b]} : {24'h0, mem_b[b]};
            else if (sz == 2'd1) begin
                h = {mem_b[b], mem_b[b+1]};
                last_rdata = (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
            end else
                last_rdata = mword(wa);
        end else begin
            e.writes = 1;
            if (sz == 2'd2) begin
                e.lat = 2; e.actions = 1;
                {mem_b[b], mem_b[b+1], mem_b[b+2], mem_b[b+3]} = wd;
            end else if (sz == 2'd1) begin
                e.lat = 3; e.actions = 2;
                {mem_b[b], mem_b[b+1]} = wd[15:0];
            end else begin
                e.lat = 3; e.actions = 2;
                mem_b[b] = wd[7:0];
            end
        end
        e.rdata = last_rdata;
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks RAM bus hygiene.
    always @(negedge i_clk) begin
        if (i_rst) begin
            act_cnt = 0;
            wr_cnt  = 0;
        end else begin
            if (o_ram_action != `RAM_NONE) begin
                act_cnt++;
                chk("ram_addr_align", {30'h0, o_ram_addr[1:0]}, 32'h0);
            end
            if (o_ram_action == `RAM_WRITE) wr_cnt++;
            else chk("ram_val_idle_zero", o_ram_val, 32'h0);
            if (o_done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(o_done), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err", 32'(o_err), 32'(e.err));
                    chk("rdata", o_rdata, e.rdata);
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("ram_actions", 32'(act_cnt), 32'(e.actions));
                    chk("ram_writes", 32'(wr_cnt), 32'(e.writes));
                    if (!e.err) chk("mem_word", ram_w[e.wa[AW-1:2]], mword(e.wa));
                end
                act_cnt = 0;
                wr_cnt  = 0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_ready) begin
            // Requests while busy must be dropped.
            i_req = 1'($urandom_range(0, 1));
            i_we = 1'($urandom); i_size = 2'($urandom); i_addr = $urandom; i_wdata = $urandom;
            n++;
            if (n > 50) begin
                chk("ready_timeout", 32'(o_ready), 32'h1);
                i_req = 1'b0;
                return;
            end
            @(negedge i_clk);
        end
        i_req = 1'b1; i_we = we; i_size = sz; i_signed = sg; i_addr = a; i_wdata = wd;
        model_req(we, sz, sg, a, wd, e);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge i_clk);
        i_req = 1'b0;
        i_we = 1'($urandom); i_size = 2'($urandom); i_signed = 1'($urandom);
        i_addr = $urandom; i_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !o_ready) && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem_b[i] = pat(i);
        #12;
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_action", 32'(o_ram_action), 32'(`RAM_NONE));
        @(negedge i_clk);
        i_rst = 1'b0;

        do_req(1, 2, 0, 32'h10, 32'hDEAD_BEEF);
        do_req(0, 2, 0, 32'h10, 32'h0);
        wait_idle(); chk("ld_word_10", o_rdata, 32'hDEAD_BEEF);
        do_req(1, 0, 0, 32'h11, 32'h0000_00A5);
        do_req(0, 2, 0, 32'h10, 32'h0);
        wait_idle(); chk("ld_after_sb", o_rdata, 32'hDEA5_BEEF);
        do_req(0, 0, 1, 32'h11, 32'h0);
        wait_idle(); chk("ld_sbyte", o_rdata, 32'hFFFF_FFA5);
        do_req(0, 0, 0, 32'h11, 32'h0);
        wait_idle(); chk("ld_ubyte", o_rdata, 32'h0000_00A5);
        do_req(1, 1, 0, 32'h12, 32'h0000_1234);
        do_req(0, 2, 0, 32'h10, 32'h0);
        wait_idle(); chk("ld_after_sh", o_rdata, 32'hDEA5_1234);
        do_req(0, 1, 1, 32'h10, 32'h0);
        wait_idle(); chk("ld_shalf", o_rdata, 32'hFFFF_DEA5);
        do_req(0, 2, 0, 32'h13, 32'h0);
        wait_idle(); chk("misaligned_keeps_rdata", o_rdata, 32'hFFFF_DEA5);
        do_req(1, 1, 0, 32'h11, 32'h0000_9999);
        do_req(0, 2, 0, 32'h10, 32'h0);
        wait_idle(); chk("mem_after_bad_store", o_rdata, 32'hDEA5_1234);
        do_req(1, 2, 0, MEM_SIZE - 4, 32'h55AA_33CC);
        do_req(0, 2, 0, MEM_SIZE - 4, 32'h0);
        wait_idle(); chk("ld_top_word", o_rdata, 32'h55AA_33CC);
        do_req(1, 2, 0, MEM_SIZE, 32'h1111_1111);
        do_req(0, 3, 0, 32'h20, 32'h0);
        wait_idle();

        // Reset in the read phase of a byte store must abort before the write.
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_size = 2'd0; i_addr = 32'h13; i_wdata = 32'h77;
        @(negedge i_clk);
        i_req = 1'b0;
        chk("rmw_read_phase", 32'(o_ram_action), 32'(`RAM_READ));
        i_rst = 1'b1;
        #1;
        chk("rst_mid_action", 32'(o_ram_action), 32'(`RAM_NONE));
        chk("rst_mid_done", 32'(o_done), 32'h0);
        chk("rst_mid_rdata", o_rdata, 32'h0);
        last_rdata = 32'h0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        do_req(0, 2, 0, 32'h10, 32'h0);
        wait_idle(); chk("mem_after_rst", o_rdata, 32'hDEA5_1234);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int r;
            r  = int'($urandom_range(0, 15));
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MEM_SIZE + 7));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
        end
        wait_idle();
        repeat (3) @(negedge i_clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
